// File: rtl/demux_pkg.sv
// Shared encodings and state type for the 1-to-4 demux scheduler.
package demux_pkg;

  // Demux select encodings, {sel_a, sel_b}.
  localparam logic [1:0] LANE_A = 2'b00;
  localparam logic [1:0] LANE_B = 2'b01;
  localparam logic [1:0] LANE_C = 2'b10;
  localparam logic [1:0] LANE_D = 2'b11;

  // Routing mode.
  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_ADDR = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/rr_next_lane.sv
// Finds the first enabled lane at or after (incl_start=1) or strictly after (incl_start=0)
// `start`, searching upward with wrap 3->0. With incl_start=0 the search ends on `start`
// itself, so a sole enabled lane returns itself.
module rr_next_lane (
  input  logic [1:0] start,
  input  logic [3:0] lane_en,
  input  logic       incl_start,
  output logic [1:0] lane,
  output logic       none
);

  // Scan from the farthest offset down so the nearest enabled lane wins.
  always_comb begin
    logic [1:0] cand;
    lane = start;
    none = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i) + 2'(!incl_start);
      if (lane_en[cand]) begin
        lane = cand;
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_1_4_scheduler.sv
// Sequencing controller for a 1-to-4 demux: routes a valid/ready stream to four lanes,
// round-robin in bursts or by per-word address, through a one-entry output register.
module demux_1_4_scheduler
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [3:0]       lane_en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic             in_ready,
  output logic [3:0]       out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic [3:0]       out_ready,
  output logic             sel_a,
  output logic             sel_b,
  output logic             drop,
  output logic             busy
);

  localparam logic [7:0] BurstLen = 8'(BURST);

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [1:0]       tgt_q;
  logic [WIDTH-1:0] data_q;
  logic             drop_q;

  logic [1:0] fix_lane, adv_lane;
  logic       fix_none, adv_none;
  logic       rr_block, accept, routable, load, drain;
  logic [1:0] new_tgt;
  logic [7:0] cnt_inc;

  // Round-robin target: ptr if enabled, else the next enabled lane above it.
  rr_next_lane u_fix (
    .start      (ptr_q),
    .lane_en    (lane_en),
    .incl_start (1'b1),
    .lane       (fix_lane),
    .none       (fix_none)
  );

  // Post-burst advance: next enabled lane strictly after the current target.
  rr_next_lane u_adv (
    .start      (fix_lane),
    .lane_en    (lane_en),
    .incl_start (1'b0),
    .lane       (adv_lane),
    .none       (adv_none)
  );

  // Handshake and routing decode.
  always_comb begin
    rr_block = (mode == MODE_RR) && (lane_en == 4'b0000);
    in_ready = rst_n && !rr_block && ((state_q == ST_IDLE) || out_ready[tgt_q]);
    accept   = in_valid && in_ready;
    new_tgt  = (mode == MODE_ADDR) ? in_sel : fix_lane;
    routable = (mode == MODE_ADDR) ? lane_en[in_sel] : !fix_none;
    load     = accept && routable;
    drain    = (state_q == ST_HOLD) && out_ready[tgt_q];
  end

  // Burst bookkeeping; a fixed-up pointer restarts the burst count.
  always_comb begin
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    cnt_inc = (lane_en[ptr_q] ? bcnt_q : 8'd0) + 8'd1;
    if (accept && (mode == MODE_RR)) begin
      if (cnt_inc >= BurstLen) begin
        ptr_d  = adv_none ? fix_lane : adv_lane;
        bcnt_d = 8'd0;
      end else begin
        ptr_d  = fix_lane;
        bcnt_d = cnt_inc;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a dropped word never moves the stage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (load) state_d = ST_HOLD;
      ST_HOLD: begin
        if (load) begin
          state_d = ST_HOLD;
        end else if (drain) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state_q == ST_HOLD) ? (4'b0001 << tgt_q) : 4'b0000;
    busy      = (state_q == ST_HOLD);
  end

  // Output stage, pointer, burst counter and drop pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= LANE_A;
      bcnt_q <= 8'd0;
      tgt_q  <= LANE_A;
      data_q <= '0;
      drop_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      bcnt_q <= bcnt_d;
      drop_q <= accept && !routable;
      if (load) begin
        tgt_q  <= new_tgt;
        data_q <= in_data;
      end
    end
  end

  assign out_data = data_q;
  assign sel_a    = tgt_q[1];
  assign sel_b    = tgt_q[0];
  assign drop     = drop_q;

endmodule

// File: doc/demux_1_4_scheduler.md
# demux_1_4_scheduler

Sequencing controller for the 1-to-4 demultiplexer datapath. It accepts a single valid/ready input stream and routes each word to one of four output lanes (A, B, C, D), either round-robin in bursts or by per-word address. It drives the demux select lines `sel_a`/`sel_b` and owns a one-entry registered output stage. It sits between a single producer and four independent consumers.

## Interface
Parameters:
- `WIDTH`, default 1: data word width in bits.
- `BURST`, default 4: words sent to one lane before round-robin advances; legal range 1..255.

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `mode`, input, 1: 0 = round-robin, 1 = addressed; sampled only on input accept.
- `lane_en`, input, 4: per-lane enable; bit i corresponds to lane i.
- `in_valid`, input, 1: input word present.
- `in_data`, input, WIDTH: input word.
- `in_sel`, input, 2: target lane in addressed mode.
- `in_ready`, output, 1: scheduler can accept a word this cycle.
- `out_valid`, output, 4: one-hot; the held word is valid for lane i.
- `out_data`, output, WIDTH: held word, shared by all lanes.
- `out_ready`, input, 4: per-lane consumer ready.
- `sel_a`, output, 1: demux select MSB.
- `sel_b`, output, 1: demux select LSB.
- `drop`, output, 1: one-cycle pulse when an accepted word is discarded.
- `busy`, output, 1: the output stage holds a word.

## Operation
- Lane mapping (a = MSB): lane 0 = A = {sel_a, sel_b} = 00, lane 1 = B = 01, lane 2 = C = 10, lane 3 = D = 11.
- FSM states:
  - IDLE: output stage empty.
  - HOLD: output stage holds a word for lane `tgt`.
- Transitions:
  - IDLE→HOLD on accept with a routable word.
  - HOLD→HOLD on a simultaneous drain and accept.
  - HOLD→IDLE on drain with no accept.
  - A word that is accepted but dropped does not leave IDLE.
- `in_ready` is combinational:
  - IDLE: 1, except 0 in round-robin mode when `lane_en` = 0000.
  - HOLD: `out_ready[tgt]`, gated by the same all-disabled rule.
- Accept = `in_valid & in_ready`. On accept:
  - latch `in_data` into `out_data`;
  - compute `tgt`;
  - set `{sel_a, sel_b}` = `tgt`.
- Round-robin target:
  - `ptr` (2 bits) and `bcnt` (8 bits) are registered.
  - If `lane_en[ptr]` = 1, `tgt` = `ptr`. Otherwise `tgt` = the next enabled lane after `ptr`, searching upward with wrap 3→0; `ptr` ← `tgt` and `bcnt` ← 0.
  - After each round-robin accept, `bcnt` increments.
  - When `bcnt` reaches `BURST`: `ptr` advances to the next enabled lane after `tgt` and `bcnt` ← 0.
  - If `tgt` is the only enabled lane, `ptr` stays and `bcnt` ← 0.
- Addressed mode:
  - `tgt` = `in_sel`.
  - If `lane_en[in_sel]` = 0, the word is accepted and discarded: `drop` = 1 for one cycle, and the output stage is unchanged.
  - `ptr` and `bcnt` are untouched.
- `out_valid` = one-hot(`tgt`) in HOLD, 0000 in IDLE.
- Drain = `out_valid[tgt] & out_ready[tgt]`.
- `busy` = (state == HOLD).
- `lane_en` changes while in HOLD do not retract the held word; it is delivered to `tgt`.
- `mode` changes take effect at the next accept.

## Timing
- Reset values:
  - state IDLE, `ptr` 0, `bcnt` 0, `tgt` 0;
  - `out_valid` 0000, `out_data` 0;
  - `sel_a` 0, `sel_b` 0;
  - `drop` 0, `busy` 0.
- Reset mid-operation:
  - the held word is lost and outputs return to reset values asynchronously;
  - `in_ready` is 0 while `rst_n` = 0.
- Latency: accept in cycle N → `out_valid` and `sel_a`/`sel_b` valid in N+1.
- Throughput: one word per cycle while the target's `out_ready` is held high.
- `out_data` and `sel_a`/`sel_b` remain stable while `out_valid` is high and not drained.
- `drop` is registered and asserts in the cycle after the dropping accept.

## Structure
- Package `demux_pkg` holds:
  - `LANE_A`..`LANE_D` select encodings;
  - `MODE_RR` and `MODE_ADDR`;
  - state typedef (`ST_IDLE`, `ST_HOLD`).
- Sub-module `rr_next_lane`:
  - combinational;
  - inputs: `start[1:0]`, `lane_en[3:0]`, `incl_start`;
  - outputs: `lane[1:0]`, `none` (no lane enabled).
  - Used for both the target fix-up and the post-burst advance.

## Test plan
- Reset, round-robin, `BURST`=2, `lane_en`=1111, 8 words 1,0,1,1,0,0,1,0 with all `out_ready` high → lanes A,A,B,B,C,C,D,D; `sel` sequence 00,00,01,01,10,10,11,11; one word per cycle.
- Round-robin with `lane_en`=0101 → only lanes A and C are served, alternating every `BURST` words; `sel_b` is always 0.
- Addressed mode, `in_sel`=2, `out_ready[2]`=0 for 3 cycles → `in_ready` stays 0 after the first accept; `out_valid`=0100 held with `out_data` stable until `out_ready[2]` rises.
- Addressed mode, `in_sel`=3 with `lane_en[3]`=0 → word accepted, `drop` pulses once, `out_valid` stays 0000.
- Round-robin, `lane_en`=0000 → `in_ready`=0. Then set `lane_en`=0010 → next word goes to lane B.
- Assert `rst_n`=0 while in HOLD for lane D → `out_valid`=0000 and `sel`=00 immediately; first word after release goes to lane A.
